// File: rtl/i2c_slave_regfile.sv
// I2C slave bridging the bus to a byte-wide register file with an
// auto-incrementing pointer; SCL/SDA are oversampled on clk.
// Ports: clk, rst_n (sync, active-low), scl_i/sda_i raw pads,
//   sda_oe pull-low enable, reg_addr/reg_wdata/reg_wr_en/reg_rdata
//   register port, busy while addressed.
module i2c_slave_regfile #(
  parameter logic [6:0] SLAVE_ADDR = 7'h2A,
  parameter int         PTR_W      = 4,
  parameter int         FILTER_LEN = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             scl_i,
  input  logic             sda_i,
  output logic             sda_oe,
  output logic [PTR_W-1:0] reg_addr,
  output logic [7:0]       reg_wdata,
  output logic             reg_wr_en,
  input  logic [7:0]       reg_rdata,
  output logic             busy
);

  localparam logic [2:0] CNT_MAX = 3'(FILTER_LEN - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_PTR, S_PTR_ACK,
    S_WDATA, S_WDATA_ACK, S_RDATA, S_RDATA_ACK
  } state_t;

  logic [1:0] scl_sync_q, scl_sync_d;
  logic [1:0] sda_sync_q, sda_sync_d;
  logic [2:0] scl_cnt_q, scl_cnt_d;
  logic [2:0] sda_cnt_q, sda_cnt_d;
  logic       scl_f_q, scl_f_d;
  logic       sda_f_q, sda_f_d;
  logic       scl_p_q, sda_p_q;

  state_t     state_q, state_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] sh_q, sh_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic       oe_q, oe_d;
  logic       busy_q, busy_d;
  logic       wr_q, wr_d;
  logic [7:0] wdata_q, wdata_d;
  logic       ack_q, ack_d;

  logic       scl_rise, scl_fall;
  logic       start_c, stop_c;
  logic [7:0] rx_byte;

  // Filtered lines flip only after FILTER_LEN consecutive differing samples.
  always_comb begin
    scl_sync_d = {scl_sync_q[0], scl_i};
    sda_sync_d = {sda_sync_q[0], sda_i};
    scl_f_d    = scl_f_q;
    sda_f_d    = sda_f_q;
    scl_cnt_d  = 3'd0;
    sda_cnt_d  = 3'd0;
    if (scl_sync_q[1] != scl_f_q) begin
      if (scl_cnt_q == CNT_MAX) scl_f_d = scl_sync_q[1];
      else scl_cnt_d = scl_cnt_q + 3'd1;
    end
    if (sda_sync_q[1] != sda_f_q) begin
      if (sda_cnt_q == CNT_MAX) sda_f_d = sda_sync_q[1];
      else sda_cnt_d = sda_cnt_q + 3'd1;
    end
  end

  assign scl_rise = scl_f_q & ~scl_p_q;
  assign scl_fall = ~scl_f_q & scl_p_q;
  assign start_c  = sda_p_q & ~sda_f_q & scl_f_q & scl_p_q;
  assign stop_c   = ~sda_p_q & sda_f_q & scl_f_q & scl_p_q;
  assign rx_byte  = {sh_q[6:0], sda_f_q};

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    ptr_d   = ptr_q;
    oe_d    = oe_q;
    busy_d  = busy_q;
    wr_d    = 1'b0;
    wdata_d = wdata_q;
    ack_d   = ack_q;
    // Pointer advances the clk after each write strobe.
    if (wr_q) ptr_d = ptr_q + PTR_W'(1);
    if (start_c) begin
      state_d = S_ADDR;
      bit_d   = 3'd7;
      oe_d    = 1'b0;
    end else if (stop_c) begin
      state_d = S_IDLE;
      oe_d    = 1'b0;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        S_ADDR: if (scl_rise) begin
          sh_d = rx_byte;
          if (bit_q == 3'd0) begin
            if (rx_byte[7:1] == SLAVE_ADDR) begin
              state_d = S_ADDR_ACK;
              busy_d  = 1'b1;
            end else begin
              state_d = S_IDLE;
              busy_d  = 1'b0;
            end
          end else bit_d = bit_q - 3'd1;
        end
        // oe_q doubles as the phase flag: first fall opens the slot,
        // second fall closes it.
        S_ADDR_ACK: if (scl_fall) begin
          if (!oe_q) oe_d = 1'b1;
          else if (sh_q[0]) begin
            state_d = S_RDATA;
            sh_d    = reg_rdata;
            oe_d    = ~reg_rdata[7];
            bit_d   = 3'd7;
          end else begin
            state_d = S_PTR;
            oe_d    = 1'b0;
            bit_d   = 3'd7;
          end
        end
        S_PTR: if (scl_rise) begin
          sh_d = rx_byte;
          if (bit_q == 3'd0) begin
            ptr_d   = rx_byte[PTR_W-1:0];
            state_d = S_PTR_ACK;
          end else bit_d = bit_q - 3'd1;
        end
        S_PTR_ACK: if (scl_fall) begin
          if (!oe_q) oe_d = 1'b1;
          else begin
            oe_d    = 1'b0;
            state_d = S_WDATA;
            bit_d   = 3'd7;
          end
        end
        S_WDATA: if (scl_rise) begin
          sh_d = rx_byte;
          if (bit_q == 3'd0) state_d = S_WDATA_ACK;
          else bit_d = bit_q - 3'd1;
        end
        S_WDATA_ACK: if (scl_fall) begin
          if (!oe_q) begin
            oe_d    = 1'b1;
            wr_d    = 1'b1;
            wdata_d = sh_q;
          end else begin
            oe_d    = 1'b0;
            state_d = S_WDATA;
            bit_d   = 3'd7;
          end
        end
        S_RDATA: if (scl_fall) begin
          if (bit_q == 3'd0) begin
            oe_d    = 1'b0;
            state_d = S_RDATA_ACK;
            ack_d   = 1'b0;
          end else begin
            sh_d  = {sh_q[6:0], 1'b0};
            oe_d  = ~sh_q[6];
            bit_d = bit_q - 3'd1;
          end
        end
        S_RDATA_ACK: begin
          if (scl_rise) begin
            ptr_d = ptr_q + PTR_W'(1);
            if (sda_f_q) begin
              state_d = S_IDLE;
              busy_d  = 1'b0;
            end else ack_d = 1'b1;
          end else if (scl_fall && ack_q) begin
            state_d = S_RDATA;
            sh_d    = reg_rdata;
            oe_d    = ~reg_rdata[7];
            bit_d   = 3'd7;
            ack_d   = 1'b0;
          end
        end
        S_IDLE: ;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
      scl_cnt_q  <= 3'd0;
      sda_cnt_q  <= 3'd0;
      scl_f_q    <= 1'b1;
      sda_f_q    <= 1'b1;
      scl_p_q    <= 1'b1;
      sda_p_q    <= 1'b1;
      state_q    <= S_IDLE;
      bit_q      <= 3'd7;
      sh_q       <= 8'd0;
      ptr_q      <= '0;
      oe_q       <= 1'b0;
      busy_q     <= 1'b0;
      wr_q       <= 1'b0;
      wdata_q    <= 8'd0;
      ack_q      <= 1'b0;
    end else begin
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      scl_cnt_q  <= scl_cnt_d;
      sda_cnt_q  <= sda_cnt_d;
      scl_f_q    <= scl_f_d;
      sda_f_q    <= sda_f_d;
      scl_p_q    <= scl_f_q;
      sda_p_q    <= sda_f_q;
      state_q    <= state_d;
      bit_q      <= bit_d;
      sh_q       <= sh_d;
      ptr_q      <= ptr_d;
      oe_q       <= oe_d;
      busy_q     <= busy_d;
      wr_q       <= wr_d;
      wdata_q    <= wdata_d;
      ack_q      <= ack_d;
    end
  end

  assign sda_oe    = oe_q;
  assign reg_addr  = ptr_q;
  assign reg_wdata = wdata_q;
  assign reg_wr_en = wr_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Directed bench for i2c_slave_regfile: bit-banged master on a
// wired-AND SDA, strobe monitor, model register array for reads.
module tb_i2c_slave_regfile;

  localparam int Q = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       m_scl = 1'b1;
  logic       m_sda = 1'b1;
  logic       glitch = 1'b0;
  logic       sda_line;
  logic       sda_oe;
  logic [3:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_wr_en;
  logic [7:0] reg_rdata;
  logic       busy;
  logic [7:0] mem [16];

  int checks = 0;
  int failures = 0;

  logic [3:0] sq_a [$];
  logic [7:0] sq_d [$];
  int         wr_run = 0;
  bit         wr_long = 1'b0;
  bit         oe_seen = 1'b0;

  assign sda_line  = (m_sda ^ glitch) & ~sda_oe;
  assign reg_rdata = mem[reg_addr];

  always #5 clk = ~clk;

  i2c_slave_regfile dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .scl_i     (m_scl),
    .sda_i     (sda_line),
    .sda_oe    (sda_oe),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_wr_en (reg_wr_en),
    .reg_rdata (reg_rdata),
    .busy      (busy)
  );

  always @(negedge clk) begin
    if (reg_wr_en) begin
      sq_a.push_back(reg_addr);
      sq_d.push_back(reg_wdata);
      wr_run++;
      if (wr_run > 1) wr_long = 1'b1;
    end else begin
      wr_run = 0;
    end
    if (sda_oe) oe_seen = 1'b1;
  end

  task automatic qw();
    repeat (Q) @(negedge clk);
  endtask

  task automatic bus_start();
    m_sda = 1'b1; qw();
    m_scl = 1'b1; qw();
    m_sda = 1'b0; qw();
    m_scl = 1'b0; qw();
  endtask

  task automatic bus_stop();
    m_sda = 1'b0; qw();
    m_scl = 1'b1; qw();
    m_sda = 1'b1; qw();
  endtask

  task automatic send_bit(input bit b, input bit glt, output bit r);
    m_sda = b; qw();
    m_scl = 1'b1;
    repeat (Q / 2) @(negedge clk);
    if (glt) begin
      glitch = 1'b1;
      @(negedge clk);
      glitch = 1'b0;
      repeat (Q / 2 - 1) @(negedge clk);
    end else begin
      repeat (Q / 2) @(negedge clk);
    end
    r = sda_line;
    qw();
    m_scl = 1'b0; qw();
  endtask

  task automatic write_byte(input logic [7:0] b, input logic [7:0] gm,
                            output bit ack);
    bit r;
    for (int i = 7; i >= 0; i--) send_bit(b[i], gm[i], r);
    send_bit(1'b1, 1'b0, r);
    ack = ~r;
  endtask

  task automatic read_byte(input bit nack, output logic [7:0] d);
    bit r;
    for (int i = 7; i >= 0; i--) begin
      send_bit(1'b1, 1'b0, r);
      d[i] = r;
    end
    send_bit(nack, 1'b0, r);
  endtask

  task automatic clear_mon();
    sq_a.delete();
    sq_d.delete();
    wr_long = 1'b0;
    oe_seen = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (sda_oe !== 1'b0) begin failures++;
      $display("FAIL rst_sda_oe got=%b exp=0", sda_oe); end
    checks++; if (reg_wr_en !== 1'b0) begin failures++;
      $display("FAIL rst_wr_en got=%b exp=0", reg_wr_en); end
    checks++; if (reg_wdata !== 8'h00) begin failures++;
      $display("FAIL rst_wdata got=%h exp=00", reg_wdata); end
    checks++; if (reg_addr !== 4'h0) begin failures++;
      $display("FAIL rst_addr got=%h exp=0", reg_addr); end
    checks++; if (busy !== 1'b0) begin failures++;
      $display("FAIL rst_busy got=%b exp=0", busy); end
  endtask

  task automatic test_write();
    bit a;
    logic [7:0] bytes [4];
    bytes = '{8'h54, 8'h03, 8'hA5, 8'h5A};
    clear_mon();
    bus_start();
    for (int i = 0; i < 4; i++) begin
      write_byte(bytes[i], 8'h00, a);
      checks++; if (a !== 1'b1) begin failures++;
        $display("FAIL wr_ack%0d got=%b exp=1", i, a); end
    end
    checks++; if (busy !== 1'b1) begin failures++;
      $display("FAIL wr_busy_hi got=%b exp=1", busy); end
    bus_stop();
    repeat (20) @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++;
      $display("FAIL wr_busy_lo got=%b exp=0", busy); end
    checks++; if (sq_a.size() !== 2) begin failures++;
      $display("FAIL wr_nstrobe got=%0d exp=2", sq_a.size()); end
    else begin
      checks++; if (sq_a[0] !== 4'd3 || sq_d[0] !== 8'hA5) begin failures++;
        $display("FAIL wr_s0 got=%h/%h exp=3/a5", sq_a[0], sq_d[0]); end
      checks++; if (sq_a[1] !== 4'd4 || sq_d[1] !== 8'h5A) begin failures++;
        $display("FAIL wr_s1 got=%h/%h exp=4/5a", sq_a[1], sq_d[1]); end
    end
    checks++; if (wr_long !== 1'b0) begin failures++;
      $display("FAIL wr_strobe_width got=long exp=1clk"); end
    checks++; if (reg_addr !== 4'd5) begin failures++;
      $display("FAIL wr_ptr got=%0d exp=5", reg_addr); end
  endtask

  task automatic test_wrap();
    bit a;
    clear_mon();
    bus_start();
    write_byte(8'h54, 8'h00, a);
    write_byte(8'h0F, 8'h00, a);
    write_byte(8'h11, 8'h00, a);
    write_byte(8'h22, 8'h00, a);
    checks++; if (a !== 1'b1) begin failures++;
      $display("FAIL wrap_ack got=%b exp=1", a); end
    bus_stop();
    repeat (20) @(negedge clk);
    checks++; if (sq_a.size() !== 2) begin failures++;
      $display("FAIL wrap_nstrobe got=%0d exp=2", sq_a.size()); end
    else begin
      checks++; if (sq_a[0] !== 4'd15 || sq_d[0] !== 8'h11) begin failures++;
        $display("FAIL wrap_s0 got=%h/%h exp=f/11", sq_a[0], sq_d[0]); end
      checks++; if (sq_a[1] !== 4'd0 || sq_d[1] !== 8'h22) begin failures++;
        $display("FAIL wrap_s1 got=%h/%h exp=0/22", sq_a[1], sq_d[1]); end
    end
    checks++; if (reg_addr !== 4'd1) begin failures++;
      $display("FAIL wrap_ptr got=%0d exp=1", reg_addr); end
  endtask

  task automatic test_read();
    bit a;
    logic [7:0] d;
    mem[2] = 8'hC3;
    mem[3] = 8'h3C;
    clear_mon();
    bus_start();
    write_byte(8'h54, 8'h00, a);
    write_byte(8'h02, 8'h00, a);
    bus_start();
    write_byte(8'h55, 8'h00, a);
    checks++; if (a !== 1'b1) begin failures++;
      $display("FAIL rd_addr_ack got=%b exp=1", a); end
    read_byte(1'b0, d);
    checks++; if (d !== 8'hC3) begin failures++;
      $display("FAIL rd_byte0 got=%h exp=c3", d); end
    read_byte(1'b1, d);
    checks++; if (d !== 8'h3C) begin failures++;
      $display("FAIL rd_byte1 got=%h exp=3c", d); end
    checks++; if (busy !== 1'b0) begin failures++;
      $display("FAIL rd_busy_nack got=%b exp=0", busy); end
    bus_stop();
    repeat (20) @(negedge clk);
    checks++; if (reg_addr !== 4'd4) begin failures++;
      $display("FAIL rd_ptr got=%0d exp=4", reg_addr); end
    checks++; if (sq_a.size() !== 0) begin failures++;
      $display("FAIL rd_nstrobe got=%0d exp=0", sq_a.size()); end
  endtask

  task automatic test_nomatch();
    bit a;
    clear_mon();
    bus_start();
    write_byte(8'h56, 8'h00, a);
    checks++; if (a !== 1'b0) begin failures++;
      $display("FAIL nm_ack got=%b exp=0", a); end
    write_byte(8'h10, 8'h00, a);
    checks++; if (a !== 1'b0) begin failures++;
      $display("FAIL nm_data_ack got=%b exp=0", a); end
    checks++; if (busy !== 1'b0) begin failures++;
      $display("FAIL nm_busy got=%b exp=0", busy); end
    bus_stop();
    repeat (20) @(negedge clk);
    checks++; if (oe_seen !== 1'b0) begin failures++;
      $display("FAIL nm_sda_oe got=1 exp=0"); end
    checks++; if (sq_a.size() !== 0) begin failures++;
      $display("FAIL nm_nstrobe got=%0d exp=0", sq_a.size()); end
  endtask

  task automatic test_glitch_partial();
    bit a;
    bit r;
    clear_mon();
    bus_start();
    write_byte(8'h54, 8'h00, a);
    write_byte(8'h01, 8'h00, a);
    write_byte(8'h80, 8'h81, a);
    checks++; if (a !== 1'b1) begin failures++;
      $display("FAIL gl_ack got=%b exp=1", a); end
    for (int i = 0; i < 5; i++) send_bit(i[0] ? 1'b0 : 1'b1, 1'b0, r);
    bus_stop();
    repeat (20) @(negedge clk);
    checks++; if (sq_a.size() !== 1) begin failures++;
      $display("FAIL gl_nstrobe got=%0d exp=1", sq_a.size()); end
    else begin
      checks++; if (sq_a[0] !== 4'd1 || sq_d[0] !== 8'h80) begin failures++;
        $display("FAIL gl_s0 got=%h/%h exp=1/80", sq_a[0], sq_d[0]); end
    end
    checks++; if (busy !== 1'b0) begin failures++;
      $display("FAIL gl_busy got=%b exp=0", busy); end
    checks++; if (reg_addr !== 4'd2) begin failures++;
      $display("FAIL gl_ptr got=%0d exp=2", reg_addr); end
  endtask

  task automatic test_reset_mid();
    bit a;
    bit r;
    int n;
    logic [7:0] p;
    p = 8'h07;
    clear_mon();
    bus_start();
    write_byte(8'h54, 8'h00, a);
    for (int i = 7; i >= 0; i--) send_bit(p[i], 1'b0, r);
    n = 0;
    while (sda_oe !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++; if (sda_oe !== 1'b1) begin failures++;
      $display("FAIL rm_ack_wait got=%b exp=1 (timeout)", sda_oe); end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++; if (sda_oe !== 1'b0) begin failures++;
      $display("FAIL rm_sda_oe got=%b exp=0", sda_oe); end
    checks++; if (busy !== 1'b0 || reg_wr_en !== 1'b0) begin failures++;
      $display("FAIL rm_busy_wr got=%b/%b exp=0/0", busy, reg_wr_en); end
    checks++; if (reg_addr !== 4'd0 || reg_wdata !== 8'h00) begin failures++;
      $display("FAIL rm_regs got=%h/%h exp=0/00", reg_addr, reg_wdata); end
    send_bit(1'b1, 1'b0, r);
    bus_stop();
    repeat (20) @(negedge clk);
    checks++; if (sq_a.size() !== 0 || busy !== 1'b0) begin failures++;
      $display("FAIL rm_after got=%0d/%b exp=0/0", sq_a.size(), busy); end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    test_reset();
    test_write();
    test_wrap();
    test_read();
    test_nomatch();
    test_glitch_partial();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
